// File: rtl/imuldiv_iter_muldiv_param_pkg.sv
// imuldiv_muldiv_pkg: function codes, FSM states and result packing for the iterative mul/div unit
package imuldiv_muldiv_pkg;
  localparam logic [2:0] MUL  = 3'd0;
  localparam logic [2:0] DIV  = 3'd1;
  localparam logic [2:0] DIVU = 3'd2;
  localparam logic [2:0] REM  = 3'd3;
  localparam logic [2:0] REMU = 3'd4;
  localparam logic [2:0] MULU = 3'd5;
  localparam int MAXW = 64;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic logic [2*MAXW-1:0] pack_result(input logic [MAXW-1:0] rem, input logic [MAXW-1:0] quo, input int unsigned w);
    return ({{MAXW{1'b0}}, rem} << w) | {{MAXW{1'b0}}, quo};
  endfunction
endpackage

// File: rtl/imuldiv_iter_muldiv_param_if.sv
// imuldiv_iter_muldiv_param_if: val/rdy request/response bus plus kill for the mul/div unit
interface imuldiv_iter_muldiv_param_if #(parameter int W = 32, parameter int TAGW = 4);
  logic [2:0]      muldivreq_msg_fn;
  logic [W-1:0]    muldivreq_msg_a;
  logic [W-1:0]    muldivreq_msg_b;
  logic [TAGW-1:0] muldivreq_msg_tag;
  logic            muldivreq_val;
  logic            muldivreq_rdy;
  logic            kill;
  logic [2*W-1:0]  muldivresp_msg_result;
  logic [TAGW-1:0] muldivresp_msg_tag;
  logic            muldivresp_val;
  logic            muldivresp_rdy;
  modport master (
    output muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_msg_tag, muldivreq_val, kill, muldivresp_rdy,
    input  muldivreq_rdy, muldivresp_msg_result, muldivresp_msg_tag, muldivresp_val
  );
  modport slave (
    input  muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_msg_tag, muldivreq_val, kill, muldivresp_rdy,
    output muldivreq_rdy, muldivresp_msg_result, muldivresp_msg_tag, muldivresp_val
  );
endinterface

// File: rtl/imuldiv_iter_muldiv_param_dpath.sv
// imuldiv_iter_muldiv_dpath: operand/accumulator registers and the shared radix-2 step adder
module imuldiv_iter_muldiv_dpath #(
  parameter int W = 32,
  parameter int TAGW = 4,
  localparam int CW = $clog2(W)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      fn_in,
  input  logic [W-1:0]    a_in,
  input  logic [W-1:0]    b_in,
  input  logic [TAGW-1:0] tag_in,
  output logic            fin,
  output logic [2*W-1:0]  result,
  output logic [TAGW-1:0] tag
);
  import imuldiv_muldiv_pkg::*;
  logic [2:0] fn;
  logic [W-1:0] mb, ma_in, mb_in, q, r, qf, rf;
  logic [2*W:0] acc, acc_nx;
  logic [CW-1:0] cnt;
  logic nq, rneg, sgn_in, sa_in, sb_in, is_mul, is_mul_in;
  logic [W:0] hi, addend;
  logic [W+1:0] sum;
  logic [2*W-1:0] p, res_nx;
  always_comb begin
    sgn_in = fn_in == MUL || fn_in == DIV || fn_in == REM;
    is_mul_in = fn_in == MUL || fn_in == MULU;
    sa_in = sgn_in & a_in[W-1];
    sb_in = sgn_in & b_in[W-1];
    ma_in = sa_in ? -a_in : a_in;
    mb_in = sb_in ? -b_in : b_in;
    is_mul = fn == MUL || fn == MULU;
    // mul adds into the upper half then shifts right; div shifts left then trial-subtracts
    hi = is_mul ? acc[2*W:W] : acc[2*W-1:W-1];
    addend = is_mul ? (acc[0] ? {1'b0, mb} : '0) : ~{1'b0, mb};
    sum = {1'b0, hi} + {1'b0, addend} + {{(W+1){1'b0}}, !is_mul};
    acc_nx = is_mul ? {1'b0, sum[W:0], acc[W-1:1]} : {sum[W+1] ? sum[W:0] : hi, acc[W-2:0], sum[W+1]};
    p = acc[2*W-1:0];
    q = acc[W-1:0];
    r = acc[2*W-1:W];
    qf = nq ? -q : q;
    rf = rneg ? -r : r;
    res_nx = fn >= 3'd6 ? '0 : is_mul ? (nq ? -p : p) : (2*W)'(pack_result(MAXW'(rf), MAXW'(qf), W));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fn <= '0;
      mb <= '0;
      acc <= '0;
      cnt <= '0;
      nq <= 1'b0;
      rneg <= 1'b0;
      fin <= 1'b0;
      result <= '0;
      tag <= '0;
    end else if (load) begin
      fn <= fn_in;
      mb <= mb_in;
      acc <= {{(W+1){1'b0}}, ma_in};
      cnt <= '0;
      nq <= (sa_in ^ sb_in) & (is_mul_in | (|b_in));
      rneg <= sa_in;
      fin <= 1'b0;
      tag <= tag_in;
    end else if (step && !fin) begin
      acc <= acc_nx;
      cnt <= cnt + 1'b1;
      fin <= cnt == CW'(W-1);
    end else if (step) begin
      result <= res_nx;
    end
  end
endmodule

// File: rtl/imuldiv_iter_muldiv_param.sv
// imuldiv_iter_muldiv_param: iterative parametrised mul/div unit with tag and kill, FSM control
module imuldiv_iter_muldiv_param import imuldiv_muldiv_pkg::*; #(
  parameter int W = 32,
  parameter int TAGW = 4
) (
  input logic clk,
  input logic reset,
  imuldiv_iter_muldiv_param_if.slave bus
);
  state_t state, nxt;
  logic fin;
  assign bus.muldivreq_rdy = state == IDLE;
  assign bus.muldivresp_val = state == DONE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bus.muldivreq_val ? CALC : IDLE;
      CALC: nxt = bus.kill ? IDLE : fin ? DONE : CALC;
      DONE: nxt = (bus.kill || bus.muldivresp_rdy) ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  imuldiv_iter_muldiv_dpath #(.W(W), .TAGW(TAGW)) dpath (
    .clk(clk),
    .reset(reset),
    .load(state == IDLE && bus.muldivreq_val),
    .step(state == CALC && !bus.kill),
    .fn_in(bus.muldivreq_msg_fn),
    .a_in(bus.muldivreq_msg_a),
    .b_in(bus.muldivreq_msg_b),
    .tag_in(bus.muldivreq_msg_tag),
    .fin(fin),
    .result(bus.muldivresp_msg_result),
    .tag(bus.muldivresp_msg_tag)
  );
endmodule

// File: tb/tb_imuldiv_iter_muldiv_param.sv
// tb_imuldiv_iter_muldiv_param: vector table, corner sequences and random ops against a reference model
module tb_imuldiv_iter_muldiv_param;
  import imuldiv_muldiv_pkg::*;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  imuldiv_iter_muldiv_param_if #(.W(32), .TAGW(4)) b32();
  imuldiv_iter_muldiv_param_if #(.W(8), .TAGW(2)) b8();
  imuldiv_iter_muldiv_param #(.W(32), .TAGW(4)) dut32(.clk(clk), .reset(reset), .bus(b32));
  imuldiv_iter_muldiv_param #(.W(8), .TAGW(2)) dut8(.clk(clk), .reset(reset), .bus(b8));
  int n_chk = 0, n_fail = 0;
  typedef struct {
    bit s;
    logic [2:0] fn;
    logic [63:0] a, b;
    logic [3:0] tag;
    logic [127:0] exp;
  } vec_t;
  vec_t vt[12];

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_model(int w, logic [2:0] fn, logic [63:0] a, logic [63:0] b);
    logic [63:0] m, pm, ua, ub, q, r, p;
    longint sa, sb;
    m = (64'd1 << w) - 1;
    pm = (w == 32) ? {64{1'b1}} : (64'd1 << (2 * w)) - 1;
    ua = a & m;
    ub = b & m;
    sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    q = 0;
    r = 0;
    case (fn)
      MUL: begin p = sa * sb; return 128'(p & pm); end
      MULU: begin p = ua * ub; return 128'(p & pm); end
      DIV, REM: begin
        if (sb == 0) begin q = m; r = ua; end
        else if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin q = ua; r = 0; end
        else begin q = 64'(sa / sb) & m; r = 64'(sa % sb) & m; end
      end
      DIVU, REMU: begin
        if (ub == 0) begin q = m; r = ua; end
        else begin q = ua / ub; r = ua % ub; end
      end
      default: return 128'd0;
    endcase
    return ({64'b0, r} << w) | {64'b0, q};
  endfunction

  task automatic drive(bit s, logic v, logic [2:0] fn, logic [63:0] a, logic [63:0] b, logic [3:0] tag);
    if (s) begin
      b8.muldivreq_val = v; b8.muldivreq_msg_fn = fn; b8.muldivreq_msg_a = a[7:0];
      b8.muldivreq_msg_b = b[7:0]; b8.muldivreq_msg_tag = tag[1:0];
    end else begin
      b32.muldivreq_val = v; b32.muldivreq_msg_fn = fn; b32.muldivreq_msg_a = a[31:0];
      b32.muldivreq_msg_b = b[31:0]; b32.muldivreq_msg_tag = tag;
    end
  endtask

  task automatic set_ctl(bit s, logic k, logic rr);
    if (s) begin b8.kill = k; b8.muldivresp_rdy = rr; end
    else begin b32.kill = k; b32.muldivresp_rdy = rr; end
  endtask

  function automatic logic rrdy(bit s); return s ? b8.muldivreq_rdy : b32.muldivreq_rdy; endfunction
  function automatic logic rval(bit s); return s ? b8.muldivresp_val : b32.muldivresp_val; endfunction
  function automatic logic [127:0] res(bit s);
    return s ? 128'(b8.muldivresp_msg_result) : 128'(b32.muldivresp_msg_result);
  endfunction
  function automatic logic [3:0] rtag(bit s);
    return s ? 4'(b8.muldivresp_msg_tag) : b32.muldivresp_msg_tag;
  endfunction

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic start_op(bit s, logic [2:0] fn, logic [63:0] a, logic [63:0] b, logic [3:0] tag, int dly);
    int n = 0;
    repeat (dly) @(negedge clk);
    drive(s, 1'b1, fn, a, b, tag);
    while (!rrdy(s) && n < 100) begin @(negedge clk); n++; end
    check("req_rdy_at_accept", 128'(rrdy(s)), 128'd1);
    @(posedge clk);
    @(negedge clk);
    drive(s, 1'b0, fn, a, b, tag);
  endtask

  task automatic wait_resp(bit s, output int lat);
    lat = 0;
    while (!rval(s) && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
  endtask

  task automatic finish_op(bit s, int dly_rsp, output logic [127:0] r, output logic [3:0] t, output int lat, output bit stable);
    wait_resp(s, lat);
    r = res(s);
    t = rtag(s);
    stable = 1;
    repeat (dly_rsp) begin
      cyc(1);
      if (res(s) !== r || rtag(s) !== t || rrdy(s) || !rval(s)) stable = 0;
    end
    set_ctl(s, 1'b0, 1'b1);
    cyc(1);
    set_ctl(s, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] pick(int w);
    logic [63:0] m = (64'd1 << w) - 1;
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return m;
      2: return 64'd1 << (w - 1);
      3: return 64'd1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  initial begin
    logic [127:0] r;
    logic [3:0] t, tm;
    int lat, w, bad;
    bit st, s;
    vt[0]  = '{0, MUL,  64'hffffffff, 64'h00000001, 4'ha, 128'hffffffff_ffffffff};
    vt[1]  = '{0, MULU, 64'hffffffff, 64'hffffffff, 4'h3, 128'hfffffffe_00000001};
    vt[2]  = '{0, DIV,  64'h0a01b044, 64'hffffb14a, 4'h5, 128'h00003372_ffffdf75};
    vt[3]  = '{0, REMU, 64'hdeadbeef, 64'h0000beef, 4'h6, 128'h0000227f_00012a90};
    vt[4]  = '{0, DIV,  64'h00000007, 64'h00000000, 4'h1, 128'h00000007_ffffffff};
    vt[5]  = '{0, DIV,  64'h80000000, 64'hffffffff, 4'h2, 128'h00000000_80000000};
    vt[6]  = '{0, DIVU, 64'h00000005, 64'h00000000, 4'h4, 128'h00000005_ffffffff};
    vt[7]  = '{0, REM,  64'hfffffff9, 64'h00000002, 4'h7, 128'hffffffff_fffffffd};
    vt[8]  = '{0, 3'd6, 64'h00001234, 64'h00005678, 4'hf, 128'h0};
    vt[9]  = '{1, MUL,  64'hf8, 64'hf8, 4'h1, 128'h0040};
    vt[10] = '{1, DIV,  64'h80, 64'hff, 4'h2, 128'h0080};
    vt[11] = '{1, DIV,  64'hf9, 64'h00, 4'h3, 128'hf9ff};
    drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
    set_ctl(0, 0, 0); set_ctl(1, 0, 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      s = i[0];
      check("rst_req_rdy", 128'(rrdy(s)), 128'd1);
      check("rst_resp_val", 128'(rval(s)), 128'd0);
      check("rst_result", res(s), 128'd0);
      check("rst_tag", 128'(rtag(s)), 128'd0);
    end
    reset = 1;
    cyc(1);
    foreach (vt[i]) begin
      start_op(vt[i].s, vt[i].fn, vt[i].a, vt[i].b, vt[i].tag, 0);
      finish_op(vt[i].s, 0, r, t, lat, st);
      check($sformatf("vec%0d_result", i), r, vt[i].exp);
      check($sformatf("vec%0d_tag", i), 128'(t), 128'(vt[i].tag & (vt[i].s ? 4'h3 : 4'hf)));
      check($sformatf("vec%0d_latency", i), 128'(lat), vt[i].s ? 128'd9 : 128'd33);
    end
    start_op(0, MULU, 64'h12345678, 64'h9abcdef0, 4'h9, 0);
    finish_op(0, 10, r, t, lat, st);
    check("backpressure_stable", 128'(st), 128'd1);
    check("backpressure_result", r, ref_model(32, MULU, 64'h12345678, 64'h9abcdef0));
    drive(0, 1, DIVU, 64'd100, 64'd7, 4'hc);
    set_ctl(0, 1, 0);
    cyc(1);
    drive(0, 0, DIVU, 64'd100, 64'd7, 4'hc);
    set_ctl(0, 0, 0);
    check("kill_idle_accepted", 128'(rrdy(0)), 128'd0);
    finish_op(0, 0, r, t, lat, st);
    check("kill_idle_result", r, 128'h00000002_0000000e);
    start_op(0, DIV, 64'd1000, 64'd3, 4'h8, 0);
    cyc(4);
    set_ctl(0, 1, 0);
    cyc(1);
    set_ctl(0, 0, 0);
    check("kill_calc_req_rdy", 128'(rrdy(0)), 128'd1);
    check("kill_calc_resp_val", 128'(rval(0)), 128'd0);
    bad = 0;
    repeat (40) begin cyc(1); if (rval(0)) bad++; end
    check("kill_calc_no_resp", 128'(bad), 128'd0);
    start_op(0, MUL, 64'd3, 64'd8, 4'hb, 0);
    finish_op(0, 0, r, t, lat, st);
    check("after_kill_mul", r, 128'h18);
    check("after_kill_tag", 128'(t), 128'hb);
    start_op(1, MULU, 64'hff, 64'hff, 4'h1, 0);
    wait_resp(1, lat);
    set_ctl(1, 1, 1);
    cyc(1);
    set_ctl(1, 0, 0);
    check("kill_done_resp_val", 128'(rval(1)), 128'd0);
    check("kill_done_req_rdy", 128'(rrdy(1)), 128'd1);
    start_op(0, MUL, 64'd5, 64'd6, 4'h7, 0);
    cyc(3);
    reset = 0;
    #1;
    check("rst_mid_req_rdy", 128'(rrdy(0)), 128'd1);
    check("rst_mid_resp_val", 128'(rval(0)), 128'd0);
    check("rst_mid_result", res(0), 128'd0);
    @(negedge clk);
    reset = 1;
    cyc(1);
    for (int i = 0; i < 260; i++) begin
      logic [2:0] fn;
      logic [63:0] a, b;
      s = i < 200;
      w = s ? 8 : 32;
      tm = s ? 4'h3 : 4'hf;
      fn = 3'($urandom_range(0, 7));
      a = pick(w);
      b = pick(w);
      t = 4'($urandom_range(0, 15)) & tm;
      start_op(s, fn, a, b, t, $urandom_range(0, 3));
      finish_op(s, $urandom_range(0, 3), r, tm, lat, st);
      check($sformatf("rand%0d_fn%0d_%h_%h", i, fn, a, b), r, ref_model(w, fn, a, b));
      check($sformatf("rand%0d_tag", i), 128'(tm), 128'(t));
      check($sformatf("rand%0d_stable", i), 128'(st), 128'd1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imuldiv_iter_muldiv_param.md
Name: imuldiv_iter_muldiv_param

Overview:
Parametrised iterative multiply/divide unit. It is the successor to the fixed 32-bit pipelined muldiv unit.
- Operand width is configurable.
- Adds an unsigned multiply mode, a request tag carried through to the response, and a kill input for squashing in-flight operations.
- Sits in the core datapath behind the X stage, using the same val/rdy request/response protocol as the existing muldiv unit.

Parameters:
W, 32, operand width in bits (8..64, even).
TAGW, 4, width of the opaque request tag returned with the response.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
muldivreq_msg_fn  input  3  operation code (see Behaviour).
muldivreq_msg_a  input  W  operand A (multiplicand / dividend).
muldivreq_msg_b  input  W  operand B (multiplier / divisor).
muldivreq_msg_tag  input  TAGW  tag returned unchanged with the result.
muldivreq_val  input  1  request valid.
muldivreq_rdy  output  1  unit can accept a request.
kill  input  1  abort the in-flight operation.
muldivresp_msg_result  output  2W  result.
muldivresp_msg_tag  output  TAGW  tag of the completed request.
muldivresp_val  output  1  response valid.
muldivresp_rdy  input  1  consumer accepts the response.

Behaviour:
Function codes:
- 0 MUL: signed A*B; full 2W product.
- 1 DIV: signed; result = {remainder, quotient}.
- 2 DIVU: unsigned; result = {remainder, quotient}.
- 3 REM: signed; result = {remainder, quotient}.
- 4 REMU: unsigned; result = {remainder, quotient}.
- 5 MULU: unsigned A*B; full 2W product.
- 6, 7: reserved. Accepted and completed with result 0 at normal latency.

Result packing:
- Remainder in [2W-1:W], quotient in [W-1:0].
- DIV/REM produce the same packing, as do DIVU/REMU; the fn code is kept only for the consumer.

FSM states:
- IDLE: muldivreq_rdy=1. On val&&rdy, latch fn/a/b/tag, take magnitudes and result signs for signed ops, clear the counter, go to CALC.
- CALC: one radix-2 step per cycle (shift-add for mul, restoring subtract for div) for exactly W cycles. When the counter reaches W-1, apply the sign correction and go to DONE.
- DONE: muldivresp_val=1; result and tag held stable. On resp_val&&resp_rdy go to IDLE.

Timing and handshake:
- Latency: a request accepted at edge t gives muldivresp_val=1 after edge t+W+1. Latency is fixed regardless of operand values.
- No combinational path from req_val to req_rdy, or from resp_rdy to resp_val.
- muldivreq_rdy=0 in CALC and DONE. There is no overlap: the next request is accepted earliest in the cycle after the response handshake.

Divide corner cases (RISC-V semantics):
- Divide by zero: quotient = all ones, remainder = A.
- Signed overflow (A = -2^(W-1), B = -1): quotient = A, remainder = 0.
- Remainder takes the sign of the dividend; quotient is truncated toward zero.

Kill:
- kill=1 in CALC or DONE forces IDLE at the next edge. No response is produced; resp_val drops that edge.
- kill in IDLE is ignored.
- kill takes priority over a simultaneous response handshake.

Reset:
- Asserting reset (0) at any time, including mid-CALC, immediately forces IDLE.
- Reset values: req_rdy=1, resp_val=0, result=0, tag=0, counter=0.

Internal widths:
- Accumulator/remainder register is 2W+1 bits; counter is $clog2(W) bits.
- Operand magnitude of -2^(W-1) is handled as an unsigned W-bit value, with no overflow.

Decomposition:
- Package imuldiv_muldiv_pkg: fn code localparams (MUL, DIV, DIVU, REM, REMU, MULU), FSM state encodings, and a result pack helper function.
- Sub-module imuldiv_iter_muldiv_dpath: accumulator, operand, counter and sign registers plus the step adder.
- The top level holds the FSM control.

Test Plan:
- W=32 MUL: a=ffffffff, b=00000001 -> result ffffffff_ffffffff. MULU with a=b=ffffffff -> fffffffe_00000001. Tag 0xA is returned unchanged.
- W=32 DIV: a=0a01b044, b=ffffb14a -> 00003372_ffffdf75. REMU: a=deadbeef, b=0000beef -> 0000227f_00012a90.
- W=32 corner cases: DIV a=00000007, b=0 -> 00000007_ffffffff. DIV a=80000000, b=ffffffff -> 00000000_80000000. DIVU by 0 with a=5 -> 00000005_ffffffff.
- Latency and backpressure: with resp_rdy=1, accept at edge t -> resp_val first high after edge t+33. With resp_rdy=0 for 10 cycles, result/tag stay stable and req_rdy stays 0.
- Kill and reset: kill 5 cycles after accept -> req_rdy=1 next cycle, resp_val never asserts, the following MUL 3*8 returns 0x18. Reset driven low mid-CALC -> req_rdy=1 and resp_val=0 immediately.
- W=8, TAGW=2: MUL a=f8, b=f8 -> 0040. DIV a=80, b=ff -> 0080. Random val/rdy delays over 200 mixed ops checked against a reference model.
